// File: rtl/circsat_search_pkg.sv
// Shared types and constants for the circuit-satisfiability brute-force solver.
package circsat_pkg;

    localparam int N_IN   = 3;
    localparam int CAND_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        EMIT,
        DONE
    } state_t;

    localparam logic [CAND_W-1:0] LAST_CAND = 3'd7;

endpackage

// File: rtl/circsat_search_eval.sv
// Combinational evaluator for the example circuit; kept as its explicit gate
// network so a different circuit can be dropped in without touching the controller.
module circsat_eval (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y
);

    logic x1, x2, x3, x4, x5, x6, x7, x8, x9, x10;

    assign x1  = a | b;
    assign x2  = a & b;
    assign x3  = ~c;
    assign x4  = x1 & x3;
    assign x5  = x2 | c;
    assign x6  = x4 & x5;
    assign x7  = a ^ b;
    assign x8  = ~x7;
    assign x9  = x8 & x1;
    assign x10 = x6 & x9;
    assign y   = x10;

endmodule

// File: rtl/circsat_search.sv
// Sequential brute-force search over {a,b,c}: streams every assignment whose
// output matches target_y on a valid/ready channel, then pulses done with a count.
module circsat_search
    import circsat_pkg::*;
#(
    parameter int COUNT_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               target_y,
    input  logic               first_only,
    input  logic               abort,
    output logic               busy,
    output logic               sol_valid,
    input  logic               sol_ready,
    output logic [CAND_W-1:0]  sol_data,
    output logic               done,
    output logic [COUNT_W-1:0] sol_count
);

    state_t              state;
    logic [CAND_W-1:0]   cand;
    logic                tgt_q;
    logic                first_q;
    logic [COUNT_W-1:0]  count;
    logic [COUNT_W-1:0]  count_inc;
    logic                y;

    circsat_eval u_eval (
        .a (cand[2]),
        .b (cand[1]),
        .c (cand[0]),
        .y (y)
    );

    assign count_inc = (count == {COUNT_W{1'b1}}) ? count : count + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cand      <= '0;
            tgt_q     <= 1'b0;
            first_q   <= 1'b0;
            count     <= '0;
            busy      <= 1'b0;
            sol_valid <= 1'b0;
            sol_data  <= '0;
            done      <= 1'b0;
            sol_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        tgt_q   <= target_y;
                        first_q <= first_only;
                        cand    <= '0;
                        count   <= '0;
                        busy    <= 1'b1;
                        state   <= EVAL;
                    end
                end
                EVAL: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (y == tgt_q) begin
                        sol_data  <= cand;
                        sol_valid <= 1'b1;
                        state     <= EMIT;
                    end else if (cand == LAST_CAND) begin
                        done      <= 1'b1;
                        sol_count <= count;
                        state     <= DONE;
                    end else begin
                        cand <= cand + 1'b1;
                    end
                end
                EMIT: begin
                    // abort outranks a coincident sol_ready: the beat is dropped uncounted
                    if (abort) begin
                        sol_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (sol_ready) begin
                        sol_valid <= 1'b0;
                        count     <= count_inc;
                        if (first_q || cand == LAST_CAND) begin
                            done      <= 1'b1;
                            sol_count <= count_inc;
                            state     <= DONE;
                        end else begin
                            cand  <= cand + 1'b1;
                            state <= EVAL;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    sol_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/circsat_search.md
Name: circsat_search

Overview:
- Sequential brute-force solver for the 3-input circuit-satisfiability function used in the examples.
- Enumerates every input assignment {a,b,c} through a combinational evaluator and compares y against a requested target.
- Streams each satisfying assignment out on a valid/ready channel, then reports a solution count.
- Serves as the classical reference against which annealer-derived solutions are checked.

Parameters:
- COUNT_W, 4, width of the solution counter; must be >= 4. The counter saturates at all-ones.

Ports:
- clk, input, 1, sole clock; all state changes on its rising edge.
- reset, input, 1, asynchronous, active-high reset.
- start, input, 1, one-cycle request to begin a search. Sampled only in IDLE.
- target_y, input, 1, required value of y. Latched on accepted start.
- first_only, input, 1, when 1, stop after the first accepted solution. Latched on accepted start.
- abort, input, 1, synchronous cancel of a running search.
- busy, output, 1, high in every state other than IDLE.
- sol_valid, output, 1, a satisfying assignment is presented.
- sol_ready, input, 1, consumer accepts sol_data.
- sol_data, output, 3, assignment {a,b,c}, with a as MSB.
- done, output, 1, one-cycle pulse at search end.
- sol_count, output, COUNT_W, number of accepted solutions. Valid while done is high and held until the next accepted start.

Behaviour:
- Reset values: busy=0, sol_valid=0, sol_data=0, done=0, sol_count=0. State is IDLE, candidate register cand=0.
- Reset asserted mid-search returns to IDLE immediately, with no done pulse.
- Evaluator function: y = a & b & ~c. It is derived from the gate network x1..x10 and must be implemented as that gate network, not simplified by hand.
- The evaluator is combinational on the registered cand.

State machine:
- IDLE:
  - start=1 latches target_y and first_only, sets cand=0, clears the count, and moves to EVAL.
  - start in any other state is ignored.
- EVAL (one candidate per clock):
  - If y(cand)==target: sol_data<=cand, sol_valid<=1, go to EMIT.
  - Else if cand==7: go to DONE.
  - Else: cand<=cand+1.
- EMIT:
  - Hold sol_valid and sol_data stable until sol_ready=1. Accepted means sol_valid & sol_ready on the same edge.
  - On acceptance: sol_valid<=0 and count<=count+1 (saturating).
  - Then, if first_only or cand==7, go to DONE; else cand<=cand+1 and return to EVAL.
- DONE:
  - done=1 for exactly one cycle and sol_count is updated; return to IDLE. busy falls on the same edge.

Abort:
- abort=1 in EVAL or EMIT forces IDLE on the next edge and drops sol_valid.
- No done pulse is generated and sol_count is not updated.
- If abort and sol_ready coincide in EMIT, abort wins and the solution counts as not accepted.
- abort has no effect in IDLE or DONE.

Wrap and termination:
- cand never wraps; the search ends after cand=7 is evaluated.
- At most 8 solutions exist (target_y=0 gives 7).

Latency with sol_ready tied high:
- Start accepted at edge k, so cand=n is evaluated in the cycle after edge k+n.
- A match at cand=n raises sol_valid after edge k+n+1.
- done rises after the edge that follows evaluation of cand=7, or after the edge that follows the final acceptance.

Decomposition:
- Package circsat_pkg:
  - N_IN=3 and CAND_W=3.
  - State enum: IDLE, EVAL, EMIT, DONE.
  - Function-less constant LAST_CAND=3'd7.
- Sub-module circsat_eval: purely combinational, 3 inputs to y, containing the gate network.
  - Lets a future function be swapped in without touching the controller.

Test Plan:
- Reset and idle: reset asserted mid-EVAL, then deasserted -> all outputs 0, busy=0, no done pulse; a new start is accepted afterwards.
- Single solution: target_y=1, first_only=0, sol_ready=1 -> exactly one beat with sol_data=3'b110, then a done pulse with sol_count=1.
- Multi-solution with backpressure:
  - Stimulus: target_y=0, sol_ready toggling 1-of-3 cycles.
  - Response: beats 0,1,2,3,4,5,7 in order, with sol_data stable while stalled; done with sol_count=7; 6 never emitted.
- first_only: target_y=0, first_only=1 -> single beat sol_data=0, then done with sol_count=1.
- Abort during EMIT: target_y=0, sol_ready=0, abort pulsed while sol_valid=1 -> sol_valid drops next cycle, busy=0, no done, sol_count keeps its previous value.
- Start while busy: a second start with target_y flipped during a search -> ignored; results match the original target.
